// File: rtl/pipe_pkg.sv
// Shared definitions for elastic inter-stage registers: stage payload layouts,
// bubble (NOP) field constants and helpers that build each stage's bubble word.
package pipe_pkg;

  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
  localparam logic        WRITE_DISABLE = 1'b0;

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic        llbit_we;
    logic        llbit_value;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic        llbit_we;
    logic        llbit_value;
  } mem_wb_t;

  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

  // A bubble writes nothing anywhere: every write-enable off, register r0.
  function automatic ex_mem_t ex_mem_bubble();
    ex_mem_t b;
    b.wdata       = ZERO_WORD;
    b.wd          = NOP_REG_ADDR;
    b.wreg        = WRITE_DISABLE;
    b.hi          = ZERO_WORD;
    b.lo          = ZERO_WORD;
    b.whilo       = WRITE_DISABLE;
    b.llbit_we    = WRITE_DISABLE;
    b.llbit_value = 1'b0;
    b.cp0_we      = WRITE_DISABLE;
    b.cp0_waddr   = NOP_REG_ADDR;
    b.cp0_wdata   = ZERO_WORD;
    return b;
  endfunction

  function automatic mem_wb_t mem_wb_bubble();
    mem_wb_t b;
    b.wdata       = ZERO_WORD;
    b.wd          = NOP_REG_ADDR;
    b.wreg        = WRITE_DISABLE;
    b.hi          = ZERO_WORD;
    b.lo          = ZERO_WORD;
    b.whilo       = WRITE_DISABLE;
    b.llbit_we    = WRITE_DISABLE;
    b.llbit_value = 1'b0;
    return b;
  endfunction

  // Ring pointer width; a single-slot ring still carries a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_ring_ptr.sv
// Ring-buffer pointer that wraps from DEPTH-1 back to 0; works for any DEPTH,
// not only powers of two. clr has priority over inc.
module pipe_ring_ptr
  import pipe_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] r_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + PTR_W'(1);
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline-stage register: DEPTH-slot ring with valid/ready handshake,
// synchronous flush, and a programmable bubble payload while empty.
module pipe_elastic_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 2,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  localparam int               CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  localparam int               PTR_W    = ptr_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_wr_ptr;
  logic [PTR_W-1:0]  w_rd_ptr;
  logic              w_push;
  logic              w_pop;

  // Handshake flags come only from r_count, so in_ready never sees out_ready.
  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  pipe_ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_push),
    .clr (flush),
    .ptr (w_wr_ptr)
  );

  pipe_ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_pop),
    .clr (flush),
    .ptr (w_rd_ptr)
  );

  // NOTE: the payload array has no reset; out_data masks unwritten slots with
  // BUBBLE, so clearing it would only cost flops and reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count    = r_count;
  assign out_data = out_valid ? r_mem[w_rd_ptr] : BUBBLE;

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Directed bench for pipe_elastic_reg: a DEPTH=2 instance with zero bubble and
// a DEPTH=3 instance with a non-zero bubble, sharing clock and reset.
module tb_pipe_elastic_reg;

  localparam logic [31:0] BUB2 = 32'h0000_0000;
  localparam logic [31:0] BUB3 = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_count;

  int checks   = 0;
  int failures = 0;

  pipe_elastic_reg #(.DATA_W(32), .DEPTH(2), .BUBBLE(BUB2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .flush     (a_flush),
    .count     (a_count)
  );

  pipe_elastic_reg #(.DATA_W(32), .DEPTH(3), .BUBBLE(BUB3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .flush     (b_flush),
    .count     (b_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect2(input string tag, input logic [31:0] cnt, input logic rdy,
                         input logic vld, input logic [31:0] data);
    check({tag, "_a_count"}, a_count, cnt);
    check({tag, "_a_in_ready"}, a_in_ready, rdy);
    check({tag, "_a_out_valid"}, a_out_valid, vld);
    check({tag, "_a_out_data"}, a_out_data, data);
  endtask

  task automatic expect3(input string tag, input logic [31:0] cnt, input logic rdy,
                         input logic vld, input logic [31:0] data);
    check({tag, "_b_count"}, b_count, cnt);
    check({tag, "_b_in_ready"}, b_in_ready, rdy);
    check({tag, "_b_out_valid"}, b_out_valid, vld);
    check({tag, "_b_out_data"}, b_out_data, data);
  endtask

  initial begin
    logic [31:0] q[$];
    int          sent;
    int          got;
    bit          mdl_push;
    bit          mdl_pop;

    rst = 1'b0;
    a_in_valid = 0; a_in_data = '0; a_out_ready = 0; a_flush = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_flush = 0;

    // Reset state
    tick(); tick();
    expect2("reset", 0, 1, 0, BUB2);
    expect3("reset", 0, 1, 0, BUB3);
    @(negedge clk);
    rst = 1'b1;

    // Streaming, DEPTH=2: first push lands on the first edge after release
    a_out_ready = 1; a_in_valid = 1; a_in_data = 32'h11;
    tick();
    expect2("stream1", 1, 1, 1, 32'h11);
    a_in_data = 32'h22;
    tick();
    expect2("stream2", 1, 1, 1, 32'h22);
    a_in_data = 32'h33;
    tick();
    expect2("stream3", 1, 1, 1, 32'h33);
    a_in_valid = 0;
    tick();
    expect2("stream_drain", 0, 1, 0, BUB2);

    // Stall/fill, DEPTH=3
    b_out_ready = 0; b_in_valid = 1; b_in_data = 32'hA;
    tick();
    expect3("fill1", 1, 1, 1, 32'hA);
    b_in_data = 32'hB;
    tick();
    expect3("fill2", 2, 1, 1, 32'hA);
    b_in_data = 32'hC;
    tick();
    expect3("fill3", 3, 0, 1, 32'hA);
    b_in_data = 32'hD;
    tick();
    expect3("full_hold", 3, 0, 1, 32'hA);
    b_out_ready = 1;
    tick();
    expect3("drain1", 2, 1, 1, 32'hB);
    tick();
    expect3("drain2", 2, 1, 1, 32'hC);
    b_in_valid = 0;
    tick();
    expect3("drain3", 1, 1, 1, 32'hD);
    tick();
    expect3("drain4", 0, 1, 0, BUB3);

    // Wrap-around, DEPTH=3, random out_ready against a queue model
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 200 && !(sent == 10 && q.size() == 0); cyc++) begin
      b_in_valid  = (sent < 10);
      b_in_data   = 32'h100 + sent;
      b_out_ready = 1'($urandom_range(0, 1));
      mdl_push = b_in_valid && (q.size() != 3);
      mdl_pop  = b_out_ready && (q.size() != 0);
      tick();
      if (mdl_pop) begin
        void'(q.pop_front());
        got++;
      end
      if (mdl_push) begin
        q.push_back(32'h100 + sent);
        sent++;
      end
      check("wrap_count", b_count, q.size());
      check("wrap_in_ready", b_in_ready, q.size() != 3);
      check("wrap_out_data", b_out_data, (q.size() != 0) ? q[0] : BUB3);
    end
    b_in_valid = 0;
    b_out_ready = 0;
    check("wrap_words_out", got, 10);

    // Flush with count=2 drops the same-cycle push and ignores out_ready
    b_in_valid = 1; b_in_data = 32'h41;
    tick();
    b_in_data = 32'h42;
    tick();
    expect3("preflush", 2, 1, 1, 32'h41);
    b_flush = 1; b_in_data = 32'h55; b_out_ready = 1;
    tick();
    expect3("flush", 0, 1, 0, BUB3);
    b_flush = 0; b_in_valid = 0;
    tick();
    expect3("postflush", 0, 1, 0, BUB3);
    b_in_valid = 1; b_in_data = 32'h66; b_out_ready = 0;
    tick();
    expect3("flush_repush", 1, 1, 1, 32'h66);
    b_in_valid = 0; b_out_ready = 1;
    tick();
    expect3("flush_repop", 0, 1, 0, BUB3);

    // Async reset mid-stream with both instances at count=2
    a_out_ready = 0; b_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h71;
    b_in_valid = 1; b_in_data = 32'h81;
    tick();
    a_in_data = 32'h72; b_in_data = 32'h82;
    tick();
    a_in_valid = 0; b_in_valid = 0;
    expect2("prereset", 2, 0, 1, 32'h71);
    expect3("prereset", 2, 1, 1, 32'h81);
    #2;
    rst = 1'b0;
    #1;
    expect2("async_reset", 0, 1, 0, BUB2);
    expect3("async_reset", 0, 1, 0, BUB3);
    @(negedge clk);
    rst = 1'b1;
    b_in_valid = 1; b_in_data = 32'h99;
    tick();
    b_in_valid = 0;
    expect3("after_reset_push", 1, 1, 1, 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
